// File: rtl/disp_scan_pwm.sv
// Multiplexed 7-segment scan driver with internal prescaler, PWM brightness,
// leading-zero blanking and a frame-synchronous double-buffered digit load.
module disp_scan_pwm #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 64,
    parameter int DUTY_BITS      = 3,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [DUTY_BITS-1:0]    brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              a_to_g,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W     = $clog2(NUM_DIGITS);
    localparam int SLOT_UNIT = SCAN_DIV >> DUTY_BITS;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_POL   = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
    localparam logic [6:0]            SEG_POL  = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic                  DP_POL   = (SEG_ACTIVE_LOW != 0);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] pend_dig;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [4*NUM_DIGITS-1:0] disp_dig;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [31:0]             on_limit;
    logic                    on_win;
    logic                    lz_run;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              seg_next;
    logic                    dp_next;

    // Active-high segment pattern, bit 6 = a ... bit 0 = g.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0:    return 7'b1111110;
            4'h1:    return 7'b0110000;
            4'h2:    return 7'b1101101;
            4'h3:    return 7'b1111001;
            4'h4:    return 7'b0110011;
            4'h5:    return 7'b1011011;
            4'h6:    return 7'b1011111;
            4'h7:    return 7'b1110000;
            4'h8:    return 7'b1111111;
            4'h9:    return 7'b1111011;
            4'hA:    return 7'b1110111;
            4'hB:    return 7'b0011111;
            4'hC:    return 7'b1001110;
            4'hD:    return 7'b0111101;
            4'hE:    return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    assign tick = (cnt == CNT_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Display takes the pending value from before this edge, so a load on
    // the wrap cycle only becomes visible one frame later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_dig   <= '0;
            pend_dp    <= '0;
            disp_dig   <= '0;
            disp_dp    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (load) begin
                pend_dig <= digits_in;
                pend_dp  <= dp_in;
            end
            if (wrap) begin
                disp_dig <= pend_dig;
                disp_dp  <= pend_dp;
            end
            frame_done <= wrap;
        end
    end

    assign on_limit = (32'(brightness) + 32'd1) * 32'(SLOT_UNIT);
    assign on_win   = (32'(cnt) < on_limit);

    always_comb begin
        lz_run    = 1'b1;
        blank_vec = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lz_run = lz_run & (disp_dig[4*k +: 4] == 4'h0);
            if (k != 0) blank_vec[k] = blank_lz & lz_run;
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib   = disp_dig[4*k +: 4];
                cur_dp    = disp_dp[k];
                cur_blank = blank_vec[k];
            end
        end
    end

    // A blanked digit keeps its anode and dp; only a_to_g is suppressed.
    always_comb begin
        an_next  = on_win ? (NUM_DIGITS'(1) << idx) : '0;
        seg_next = (on_win && !cur_blank) ? seg_decode(cur_nib) : '0;
        dp_next  = on_win & cur_dp;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an     <= AN_POL;
            a_to_g <= SEG_POL;
            dp     <= DP_POL;
        end else begin
            an     <= an_next ^ AN_POL;
            a_to_g <= seg_next ^ SEG_POL;
            dp     <= dp_next ^ DP_POL;
        end
    end

endmodule

// File: tb/tb_disp_scan_pwm.sv
// Directed bench for disp_scan_pwm at NUM_DIGITS=4, SCAN_DIV=8, DUTY_BITS=3.
// After the m-th rising edge following reset release the outputs show the
// scan position of cycle m-1: idx = ((m-1)/8)%4, cnt = (m-1)%8.
module tb_disp_scan_pwm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [2:0]  brightness = 3'd7;
    logic [3:0]  an;
    logic [6:0]  a_to_g;
    logic        dp;
    logic        frame_done;

    int ecount;
    int passed = 0;
    int fails = 0;
    int total = 0;
    int on_cnt;

    disp_scan_pwm #(
        .NUM_DIGITS(4),
        .SCAN_DIV(8),
        .DUTY_BITS(3),
        .AN_ACTIVE_LOW(1),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .digits_in(digits_in),
        .dp_in(dp_in),
        .load(load),
        .blank_lz(blank_lz),
        .brightness(brightness),
        .an(an),
        .a_to_g(a_to_g),
        .dp(dp),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge that follows rising edge m.
    task automatic at(input int m);
        int guard = 0;
        while (ecount < m && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (ecount != m) begin
            total++;
            fails++;
            $display("FAIL edge_wait_%0d: observed=%0d expected=%0d", m, ecount, m);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_an", an, 4'b1111);
        chk("rst_seg", a_to_g, 7'b1111111);
        chk("rst_dp", dp, 1'b1);
        chk("rst_fd", frame_done, 1'b0);
        rst_n = 1'b1;

        // Free-running scan of zeros at full brightness
        at(1);  chk("d0_an", an, 4'b1110); chk("d0_seg", a_to_g, 7'b0000001); chk("d0_dp", dp, 1'b1);
        at(9);  chk("d1_an", an, 4'b1101); chk("d1_seg", a_to_g, 7'b0000001);
        at(17); chk("d2_an", an, 4'b1011);
        at(25); chk("d3_an", an, 4'b0111);
        at(31); chk("fd_before", frame_done, 1'b0);
        at(32); chk("fd_pulse", frame_done, 1'b1); chk("fd_an", an, 4'b0111);
        at(33); chk("fd_after", frame_done, 1'b0); chk("wrap_an", an, 4'b1110);

        // Mid-frame load: current frame stays on zeros
        at(40); digits_in = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
        at(41); load = 1'b0;
        at(50); chk("old_seg", a_to_g, 7'b0000001); chk("old_dp", dp, 1'b1);
        at(64); chk("sw_fd", frame_done, 1'b1); chk("sw_old_seg", a_to_g, 7'b0000001);
        at(65); chk("new_d0_an", an, 4'b1110); chk("new_d0_F", a_to_g, 7'b0111000); chk("new_d0_dp", dp, 1'b1);
        at(73); chk("new_d1_A", a_to_g, 7'b0001000);
        at(81); chk("new_d2_2", a_to_g, 7'b0010010); chk("new_d2_dp", dp, 1'b0);
        at(89); chk("new_d3_1", a_to_g, 7'b1001111); chk("new_d3_dp", dp, 1'b1);

        // Leading-zero blanking with 0050
        at(90); blank_lz = 1'b1; digits_in = 16'h0050; dp_in = 4'b0000; load = 1'b1;
        at(91); load = 1'b0;
        at(97);  chk("lz_d0", a_to_g, 7'b0000001);
        at(105); chk("lz_d1", a_to_g, 7'b0100100);
        at(113); chk("lz_d2_an", an, 4'b1011); chk("lz_d2_seg", a_to_g, 7'b1111111);
        at(121); chk("lz_d3_seg", a_to_g, 7'b1111111);

        // All zeros: only digit0 lit, blanked digit3 keeps its dp
        at(122); digits_in = 16'h0000; dp_in = 4'b1000; load = 1'b1;
        at(123); load = 1'b0;
        at(129); chk("z_d0", a_to_g, 7'b0000001);
        at(137); chk("z_d1", a_to_g, 7'b1111111);
        at(153); chk("z_d3_an", an, 4'b0111); chk("z_d3_seg", a_to_g, 7'b1111111); chk("z_d3_dp", dp, 1'b0);

        // PWM: brightness 0 -> one cycle per slot
        at(160); brightness = 3'd0;
        at(161); chk("b0_on", an, 4'b1110); chk("b0_on_seg", a_to_g, 7'b0000001);
        at(162); chk("b0_off_an", an, 4'b1111); chk("b0_off_seg", a_to_g, 7'b1111111); chk("b0_off_dp", dp, 1'b1);
        at(169); chk("b0_next", an, 4'b1101);

        // brightness 3 -> four cycles per slot
        at(176); brightness = 3'd3;
        on_cnt = 0;
        for (int m = 177; m <= 184; m++) begin
            at(m);
            if (m == 177) chk("b3_first", an, 4'b1011);
            if (an != 4'b1111) on_cnt++;
        end
        chk("b3_on_cycles", on_cnt, 4);
        brightness = 3'd7;

        // Load on the wrap cycle is deferred by one frame
        at(191); digits_in = 16'h8888; dp_in = 4'b0000; load = 1'b1;
        at(192); load = 1'b0; chk("lw_fd", frame_done, 1'b1);
        at(193); chk("lw_old_d0", a_to_g, 7'b0000001);
        at(201); chk("lw_old_d1", a_to_g, 7'b1111111);
        at(225); chk("lw_new_d0", a_to_g, 7'b0000000);
        at(233); chk("lw_new_d1", a_to_g, 7'b0000000);

        // Reset at idx=2, cnt=5: outputs off before the next rising edge
        at(245); chk("pre_rst_an", an, 4'b1011);
        rst_n = 1'b0;
        #1;
        chk("mrst_an", an, 4'b1111);
        chk("mrst_seg", a_to_g, 7'b1111111);
        chk("mrst_dp", dp, 1'b1);
        chk("mrst_fd", frame_done, 1'b0);
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        at(1);  chk("post_d0_an", an, 4'b1110); chk("post_d0_seg", a_to_g, 7'b0000001);
        at(9);  chk("post_d1_an", an, 4'b1101); chk("post_d1_seg", a_to_g, 7'b0000001); chk("post_d1_dp", dp, 1'b1);
        at(32); chk("post_fd", frame_done, 1'b1);
        at(33); chk("post_pend_clr", a_to_g, 7'b0000001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
